// File: rtl/argmax_classifier.sv
// -----------------------------------------------------------------------------
// argmax_classifier
//
// Purpose:
//   Sits after the final dense layer. When the layer's level-type ready flag
//   rises, the parallel signed scores are copied into a local buffer and
//   scanned one compare per cycle. The index and value of the largest score
//   are then offered to the consumer on a valid/accept handshake.
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   asynchronous, active-low reset
//   inputs_ready  in   level flag from the layer; a rising edge means new scores
//   inputs        in   NUM_CLASSES packed signed scores, class i at
//                      [i*DATA_WIDTH +: DATA_WIDTH]
//   class_index   out  index of the maximum score (lowest index on ties)
//   class_score   out  maximum score
//   class_valid   out  result available, held until accepted
//   class_accept  in   consumer takes the result while class_valid=1
//   busy          out  1 while scanning or holding a result
//   class_margin  out  best minus second-best score (ARGMAX_MARGIN_EN only)
//   dbg_state     out  current FSM state (0=IDLE, 1=SCAN, 2=DONE)
//
// Handshake: class_valid rises once the scan completes and stays high, with
//   class_index/class_score (and class_margin) stable, until a clock edge sees
//   class_accept=1. class_valid drops the following cycle. class_accept is
//   ignored whenever class_valid=0. Result outputs keep the last result after
//   acceptance until the next scan completes.
//
// Build option:
//   `define ARGMAX_MARGIN_EN  adds second-best tracking and the class_margin
//   port. Without it the port and that logic are absent; timing is identical.
// -----------------------------------------------------------------------------
module argmax_classifier #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLASSES = 10,
  parameter int INDEX_WIDTH = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              inputs_ready,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] inputs,
  output logic [INDEX_WIDTH-1:0]            class_index,
  output logic [DATA_WIDTH-1:0]             class_score,
  output logic                              class_valid,
  input  logic                              class_accept,
  output logic                              busy,
`ifdef ARGMAX_MARGIN_EN
  output logic [DATA_WIDTH:0]               class_margin,
`endif
  output logic [1:0]                        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_CLASSES - 1);

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic                          r_ready_q;
  logic signed [DATA_WIDTH-1:0]  r_buf [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0]  r_best;
  logic [INDEX_WIDTH-1:0]        r_idx;
  logic [INDEX_WIDTH-1:0]        r_cnt;
  logic [INDEX_WIDTH-1:0]        r_out_idx;
  logic [DATA_WIDTH-1:0]         r_out_score;

  logic                          w_start;
  logic                          w_last;
  logic signed [DATA_WIDTH-1:0]  w_cand;
  logic                          w_gt;
  logic signed [DATA_WIDTH-1:0]  w_next_best;
  logic [INDEX_WIDTH-1:0]        w_next_idx;

  // Only a rising edge of the level flag starts a scan.
  assign w_start     = inputs_ready & ~r_ready_q;
  assign w_last      = (r_cnt == LAST_IDX);
  assign w_cand      = r_buf[r_cnt];
  // Strict compare keeps the earliest index when scores tie.
  assign w_gt        = (w_cand > r_best);
  assign w_next_best = w_gt ? w_cand : r_best;
  assign w_next_idx  = w_gt ? r_cnt  : r_idx;

`ifdef ARGMAX_MARGIN_EN
  localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH-1:0]  r_second;
  logic signed [DATA_WIDTH-1:0]  w_next_second;
  logic [DATA_WIDTH:0]           w_margin_nxt;
  logic [DATA_WIDTH:0]           r_margin;

  // A displaced best becomes the runner-up; a tie with best lands here too,
  // which is what makes the margin 0 on ties.
  assign w_next_second = w_gt ? r_best :
                         ((w_cand > r_second) ? w_cand : r_second);
  // Sign-extend by one bit so MAX - MIN cannot overflow.
  assign w_margin_nxt  = {w_next_best[DATA_WIDTH-1], w_next_best}
                       - {w_next_second[DATA_WIDTH-1], w_next_second};
  assign class_margin  = r_margin;
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = (NUM_CLASSES == 1) ? S_DONE : S_SCAN;
      S_SCAN: if (w_last)  w_state_nxt = S_DONE;
      S_DONE: if (class_accept) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: edge detect, score buffer, running maximum, result registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ready_q   <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) r_buf[i] <= '0;
      r_best      <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_out_idx   <= '0;
      r_out_score <= '0;
`ifdef ARGMAX_MARGIN_EN
      r_second    <= '0;
      r_margin    <= '0;
`endif
    end else begin
      r_ready_q <= inputs_ready;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            for (int i = 0; i < NUM_CLASSES; i++)
              r_buf[i] <= inputs[i*DATA_WIDTH +: DATA_WIDTH];
            r_best <= inputs[DATA_WIDTH-1:0];
            r_idx  <= '0;
            r_cnt  <= INDEX_WIDTH'(1);
`ifdef ARGMAX_MARGIN_EN
            r_second <= MOST_NEG;
`endif
            // A single class needs no scan: publish it straight away.
            if (NUM_CLASSES == 1) begin
              r_out_idx   <= '0;
              r_out_score <= inputs[DATA_WIDTH-1:0];
`ifdef ARGMAX_MARGIN_EN
              r_margin    <= '0;
`endif
            end
          end
        end
        S_SCAN: begin
          r_best <= w_next_best;
          r_idx  <= w_next_idx;
`ifdef ARGMAX_MARGIN_EN
          r_second <= w_next_second;
`endif
          if (w_last) begin
            // Publish the post-compare values of the final element.
            r_out_idx   <= w_next_idx;
            r_out_score <= w_next_best;
`ifdef ARGMAX_MARGIN_EN
            r_margin    <= w_margin_nxt;
`endif
          end else begin
            r_cnt <= r_cnt + INDEX_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign class_index = r_out_idx;
  assign class_score = r_out_score;
  assign class_valid = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_argmax_classifier.sv
module tb_argmax_classifier;

  localparam int DW = 32;
  localparam int N  = 10;
  localparam int IW = 4;
  localparam int EW = (DW + 1) + IW + DW;   // {margin, index, score}
  localparam logic signed [DW-1:0] MINV = 32'h8000_0000;

  // ---------------- clock / reset ----------------
  logic            clock = 1'b0;
  logic            reset;
  logic            inputs_ready;
  logic [N*DW-1:0] inputs;
  logic [IW-1:0]   class_index;
  logic [DW-1:0]   class_score;
  logic            class_valid;
  logic            class_accept;
  logic            busy;
  logic [1:0]      dbg_state;
`ifdef ARGMAX_MARGIN_EN
  logic [DW:0]     class_margin;
`endif

  always #5 clock = ~clock;

  argmax_classifier #(.DATA_WIDTH(DW), .NUM_CLASSES(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .inputs_ready (inputs_ready),
    .inputs       (inputs),
    .class_index  (class_index),
    .class_score  (class_score),
    .class_valid  (class_valid),
    .class_accept (class_accept),
    .busy         (busy),
`ifdef ARGMAX_MARGIN_EN
    .class_margin (class_margin),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0]         exp_q[$];
  logic signed [DW-1:0]  tb_scores [N];
  int                    n_tests = 0;
  int                    n_fail  = 0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: argmax with lowest-index tie break; margin is best minus the
  // largest of all the other scores.
  task automatic model(output logic [IW-1:0] mi, output logic [DW-1:0] mb,
                       output logic [DW:0] mm);
    logic signed [DW-1:0] best, other;
    mi = '0;
    best = tb_scores[0];
    for (int i = 1; i < N; i++)
      if (tb_scores[i] > best) begin
        best = tb_scores[i];
        mi = IW'(i);
      end
    other = MINV;
    for (int i = 0; i < N; i++)
      if (i != int'(mi) && tb_scores[i] > other) other = tb_scores[i];
    mb = best;
    mm = {best[DW-1], best} - {other[DW-1], other};
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_inputs();
    for (int i = 0; i < N; i++) inputs[i*DW +: DW] = tb_scores[i];
  endtask

  // Call at a negedge: loads scores, records the expectation, raises the flag.
  task automatic drive_start();
    logic [IW-1:0] mi;
    logic [DW-1:0] mb;
    logic [DW:0]   mm;
    apply_inputs();
    model(mi, mb, mm);
    exp_q.push_back({mm, mi, mb});
    inputs_ready = 1'b1;
  endtask

  // Latency in edges from the start-sampling edge to class_valid; -1 on timeout.
  task automatic wait_valid(input int edges_done, output int lat);
    int n;
    n = edges_done;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (class_valid) begin
        lat = n - 1;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag);
    logic [EW-1:0] e;
    check({tag, "_qnonempty"}, 72'(exp_q.size() > 0), 72'(1));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_index"}, 72'(class_index), 72'(e[DW +: IW]));
      check({tag, "_score"}, 72'(class_score), 72'(e[DW-1:0]));
`ifdef ARGMAX_MARGIN_EN
      check({tag, "_margin"}, 72'(class_margin), 72'(e[EW-1 -: DW+1]));
`endif
    end
  endtask

  // Call at a negedge with class_valid=1.
  task automatic do_accept(input string tag);
    class_accept = 1'b1;
    @(posedge clock);
    @(negedge clock);
    class_accept = 1'b0;
    check({tag, "_valid_drop"}, 72'(class_valid), 72'(0));
    check({tag, "_busy_drop"},  72'(busy), 72'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    bit seen;
    reset = 1'b0;
    inputs_ready = 1'b0;
    class_accept = 1'b0;
    inputs = '0;
    repeat (3) @(negedge clock);

    check("rst_valid", 72'(class_valid), 72'(0));
    check("rst_busy",  72'(busy), 72'(0));
    check("rst_index", 72'(class_index), 72'(0));
    check("rst_score", 72'(class_score), 72'(0));
    check("rst_state", 72'(dbg_state), 72'(0));
`ifdef ARGMAX_MARGIN_EN
    check("rst_margin", 72'(class_margin), 72'(0));
`endif
    reset = 1'b1;
    @(negedge clock);

    // accept while idle is ignored
    class_accept = 1'b1;
    repeat (2) @(negedge clock);
    class_accept = 1'b0;
    check("idle_accept_state", 72'(dbg_state), 72'(0));
    check("idle_accept_valid", 72'(class_valid), 72'(0));

    // basic, with a tie at indices 2 and 4
    tb_scores = '{3, -1, 7, 2, 7, 0, -5, 1, 6, 4};
    drive_start();
    wait_valid(0, lat);
    check("basic_latency", 72'(lat), 72'(9));
    check("basic_busy", 72'(busy), 72'(1));
    check("basic_index_const", 72'(class_index), 72'(2));
    check("basic_score_const", 72'(class_score), 72'(7));
    check_result("basic");

    // hold for 20 cycles without accept
    inputs_ready = 1'b0;
    seen = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!(class_valid === 1'b1 && class_index === 4'd2 && class_score === 32'd7))
        seen = 1'b0;
    end
    check("hold_stable", 72'(seen), 72'(1));
    do_accept("basic");
    check("post_accept_index_hold", 72'(class_index), 72'(2));
    check("post_accept_score_hold", 72'(class_score), 72'(7));

    // all negative, started the cycle after accept; accept pulsed mid-scan
    tb_scores = '{-9, -3, -8, -7, -6, -5, -10, -12, -11, -4};
    drive_start();
    class_accept = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("neg_in_scan", 72'(dbg_state), 72'(1));
    @(posedge clock);
    @(negedge clock);
    class_accept = 1'b0;
    check("neg_accept_ignored", 72'(busy), 72'(1));
    wait_valid(2, lat);
    check("neg_latency", 72'(lat), 72'(9));
    check("neg_score_const", 72'(class_score), 72'(32'hFFFF_FFFD));
    check_result("allneg");
    do_accept("allneg");

    // busy drop: new rising edge and new scores during SCAN and DONE
    inputs_ready = 1'b0;
    @(negedge clock);
    tb_scores = '{5, 1, 2, 8, 3, 8, 0, -2, 4, 7};
    drive_start();
    repeat (2) begin
      @(posedge clock);
      @(negedge clock);
    end
    inputs_ready = 1'b0;
    tb_scores = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 50};
    apply_inputs();
    @(posedge clock);
    @(negedge clock);
    inputs_ready = 1'b1;
    wait_valid(3, lat);
    check("drop_latency", 72'(lat), 72'(9));
    check_result("busy_drop");
    inputs_ready = 1'b0;
    @(negedge clock);
    inputs_ready = 1'b1;
    @(negedge clock);
    check("done_drop_valid", 72'(class_valid), 72'(1));
    check("done_drop_index", 72'(class_index), 72'(3));
    do_accept("busy_drop");
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (class_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    check("no_second_result", 72'(seen), 72'(0));
    inputs_ready = 1'b0;
    @(negedge clock);
    drive_start();
    wait_valid(0, lat);
    check("restart_latency", 72'(lat), 72'(9));
    check_result("restart");
    inputs_ready = 1'b0;
    do_accept("restart");

    // reset during SCAN
    tb_scores = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    drive_start();
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    inputs_ready = 1'b0;
    #1;
    check("midrst_valid", 72'(class_valid), 72'(0));
    check("midrst_busy",  72'(busy), 72'(0));
    check("midrst_index", 72'(class_index), 72'(0));
    check("midrst_score", 72'(class_score), 72'(0));
    check("midrst_state", 72'(dbg_state), 72'(0));
`ifdef ARGMAX_MARGIN_EN
    check("midrst_margin", 72'(class_margin), 72'(0));
`endif
    check("midrst_pending", 72'(exp_q.size()), 72'(1));
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    tb_scores = '{-1, -2, 30, -4, 29, 30, 0, 0, 0, 0};
    drive_start();
    wait_valid(0, lat);
    check("postrst_latency", 72'(lat), 72'(9));
    check("postrst_index_const", 72'(class_index), 72'(2));
    check_result("post_reset");
    inputs_ready = 1'b0;
    do_accept("post_reset");

    // margin cases padded with most-negative scores
    for (int i = 0; i < N; i++) tb_scores[i] = MINV;
    tb_scores[0] = 100; tb_scores[1] = 40; tb_scores[2] = -20; tb_scores[3] = 90;
    drive_start();
    wait_valid(0, lat);
    check("m1_index_const", 72'(class_index), 72'(0));
`ifdef ARGMAX_MARGIN_EN
    check("m1_margin_const", 72'(class_margin), 72'(10));
`endif
    check_result("margin1");
    inputs_ready = 1'b0;
    do_accept("margin1");
    for (int i = 0; i < N; i++) tb_scores[i] = MINV;
    tb_scores[1] = MINV + 1;
    drive_start();
    wait_valid(0, lat);
    check("m2_index_const", 72'(class_index), 72'(1));
`ifdef ARGMAX_MARGIN_EN
    check("m2_margin_const", 72'(class_margin), 72'(1));
`endif
    check_result("margin2");
    inputs_ready = 1'b0;
    do_accept("margin2");

    // random scores in a narrow range so ties are common
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) tb_scores[i] = $urandom_range(0, 8) - 4;
      @(negedge clock);
      drive_start();
      wait_valid(0, lat);
      check("rand_latency", 72'(lat), 72'(9));
      check_result("rand");
      inputs_ready = 1'b0;
      do_accept("rand");
    end

    check("queue_empty", 72'(exp_q.size()), 72'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
